// File: rtl/rcv_deframer.sv
// Receive deframer: strips the 0x55/0xD5 preamble from the PHY nibble
// stream, rebuilds bytes low nibble first and issues an end-of-frame
// control word with length, error flag and frame statistics.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for phy_rx_dv; first valid nibble is a preamble nibble
// PRE   | counting 0x5 preamble nibbles, looking for the SFD high nibble D
// DATA  | reassembling payload bytes
// DROP  | discarding nibbles until phy_rx_dv falls (silent or oversize)
module rcv_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 2047,
  parameter int STAT_W  = 16
) (
  input  logic              clk_phy,
  input  logic              reset_n,
  input  logic [3:0]        phy_data_in,
  input  logic              phy_rx_dv,
  output logic [7:0]        f_data_out,
  output logic              f_data_valid,
  output logic [23:0]       f_ctrl_out,
  output logic              f_frame_valid,
  output logic              f_frame_err,
  output logic [STAT_W-1:0] stat_good,
  output logic [STAT_W-1:0] stat_bad
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [11:0] MIN_CNT  = 12'(MIN_LEN);
  localparam logic [11:0] MAX_CNT  = 12'(MAX_LEN);
  localparam logic [11:0] OVER_CNT = 12'(MAX_LEN + 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  state_t            state, state_d;
  logic              phase, phase_d;
  logic [1:0]        pre_cnt, pre_cnt_d;
  logic [11:0]       byte_cnt, byte_cnt_d;
  logic [3:0]        low_nib, low_nib_d;
  logic              oversize, oversize_d;
  logic              silent, silent_d;
  logic [7:0]        data_d;
  logic              data_valid_d;
  logic [23:0]       ctrl_d;
  logic              frame_valid_d;
  logic              frame_err_d;
  logic [STAT_W-1:0] good_d, bad_d;

  // Register the FSM, its context and every output.
  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      phase         <= 1'b0;
      pre_cnt       <= 2'd0;
      byte_cnt      <= 12'd0;
      low_nib       <= 4'd0;
      oversize      <= 1'b0;
      silent        <= 1'b0;
      f_data_out    <= 8'd0;
      f_data_valid  <= 1'b0;
      f_ctrl_out    <= 24'd0;
      f_frame_valid <= 1'b0;
      f_frame_err   <= 1'b0;
      stat_good     <= '0;
      stat_bad      <= '0;
    end else begin
      state         <= state_d;
      phase         <= phase_d;
      pre_cnt       <= pre_cnt_d;
      byte_cnt      <= byte_cnt_d;
      low_nib       <= low_nib_d;
      oversize      <= oversize_d;
      silent        <= silent_d;
      f_data_out    <= data_d;
      f_data_valid  <= data_valid_d;
      f_ctrl_out    <= ctrl_d;
      f_frame_valid <= frame_valid_d;
      f_frame_err   <= frame_err_d;
      stat_good     <= good_d;
      stat_bad      <= bad_d;
    end
  end

  // Next-state, context and output decode; strobes default low.
  always_comb begin
    state_d       = state;
    phase_d       = phase;
    pre_cnt_d     = pre_cnt;
    byte_cnt_d    = byte_cnt;
    low_nib_d     = low_nib;
    oversize_d    = oversize;
    silent_d      = silent;
    data_d        = f_data_out;
    data_valid_d  = 1'b0;
    ctrl_d        = f_ctrl_out;
    frame_valid_d = 1'b0;
    frame_err_d   = f_frame_err;
    good_d        = stat_good;
    bad_d         = stat_bad;

    case (state)
      IDLE: begin
        pre_cnt_d  = 2'd0;
        phase_d    = 1'b0;
        oversize_d = 1'b0;
        silent_d   = 1'b0;
        // The nibble that raises dv is judged as the first preamble nibble.
        if (phy_rx_dv) begin
          if (phy_data_in == 4'h5) begin
            state_d   = PRE;
            pre_cnt_d = 2'd1;
          end else begin
            state_d  = DROP;
            silent_d = 1'b1;
          end
        end
      end
      PRE: begin
        if (!phy_rx_dv) begin
          state_d = IDLE;
        end else if (phy_data_in == 4'h5) begin
          if (pre_cnt != 2'd3) pre_cnt_d = pre_cnt + 2'd1;
        end else if (phy_data_in == 4'hD && pre_cnt >= 2'd2) begin
          state_d    = DATA;
          phase_d    = 1'b0;
          byte_cnt_d = 12'd0;
        end else begin
          state_d  = DROP;
          silent_d = 1'b1;
        end
      end
      DATA: begin
        if (!phy_rx_dv) begin
          // A dangling low nibble is not counted but flags the frame.
          state_d       = IDLE;
          phase_d       = 1'b0;
          frame_valid_d = 1'b1;
          ctrl_d        = {byte_cnt, byte_cnt};
          frame_err_d   = phase | (byte_cnt < MIN_CNT);
        end else if (!phase) begin
          low_nib_d = phy_data_in;
          phase_d   = 1'b1;
        end else if (byte_cnt == MAX_CNT) begin
          state_d    = DROP;
          phase_d    = 1'b0;
          byte_cnt_d = OVER_CNT;
          oversize_d = 1'b1;
          silent_d   = 1'b0;
        end else begin
          data_d       = {phy_data_in, low_nib};
          data_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt + 12'd1;
          phase_d      = 1'b0;
        end
      end
      DROP: begin
        if (!phy_rx_dv) begin
          state_d = IDLE;
          if (!silent && oversize) begin
            frame_valid_d = 1'b1;
            frame_err_d   = 1'b1;
            ctrl_d        = {OVER_CNT, OVER_CNT};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Statistics move together with the end-of-frame strobe.
    if (frame_valid_d) begin
      if (frame_err_d) begin
        if (stat_bad != STAT_MAX) bad_d = stat_bad + 1'b1;
      end else begin
        if (stat_good != STAT_MAX) good_d = stat_good + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rcv_deframer.sv
// Directed bench for rcv_deframer: sends preamble-framed nibble streams and
// compares delivered bytes and end-of-frame words with hand-derived values.
module tb_rcv_deframer;

  logic        clk_phy = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  phy_data_in = 4'h0;
  logic        phy_rx_dv = 1'b0;
  logic [7:0]  f_data_out;
  logic        f_data_valid;
  logic [23:0] f_ctrl_out;
  logic        f_frame_valid;
  logic        f_frame_err;
  logic [15:0] stat_good;
  logic [15:0] stat_bad;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int overlap = 0;

  logic [7:0]  byte_q[$];
  int          byte_cyc_q[$];
  logic [23:0] ctrl_q[$];
  logic        err_q[$];
  int          fv_cyc_q[$];

  rcv_deframer dut (
    .clk_phy(clk_phy), .reset_n(reset_n), .phy_data_in(phy_data_in),
    .phy_rx_dv(phy_rx_dv), .f_data_out(f_data_out), .f_data_valid(f_data_valid),
    .f_ctrl_out(f_ctrl_out), .f_frame_valid(f_frame_valid), .f_frame_err(f_frame_err),
    .stat_good(stat_good), .stat_bad(stat_bad)
  );

  always #5 clk_phy = ~clk_phy;

  always @(posedge clk_phy) cyc++;

  // Record strobes half a cycle after the active edge.
  always @(negedge clk_phy) begin
    if (reset_n) begin
      if (f_data_valid) begin
        byte_q.push_back(f_data_out);
        byte_cyc_q.push_back(cyc);
      end
      if (f_frame_valid) begin
        ctrl_q.push_back(f_ctrl_out);
        err_q.push_back(f_frame_err);
        fv_cyc_q.push_back(cyc);
      end
      if (f_data_valid && f_frame_valid) overlap++;
    end
  end

  task automatic clear_q();
    byte_q.delete(); byte_cyc_q.delete();
    ctrl_q.delete(); err_q.delete(); fv_cyc_q.delete();
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk_phy);
    phy_rx_dv   = 1'b1;
    phy_data_in = n;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_phy);
      phy_rx_dv   = 1'b0;
      phy_data_in = 4'h0;
    end
  endtask

  task automatic send_preamble(input bit bad_pre);
    for (int i = 0; i < 15; i++) send_nib((bad_pre && i == 4) ? 4'h3 : 4'h5);
    send_nib(4'hD);
  endtask

  // Preamble, payload bytes (first_val + i) mod 256, optional stray nibble,
  // then exactly one idle cycle.
  task automatic send_frame(input int nbytes, input int first_val,
                            input bit extra_nib, input bit bad_pre);
    logic [7:0] b;
    send_preamble(bad_pre);
    for (int i = 0; i < nbytes; i++) begin
      b = 8'((first_val + i) & 255);
      send_nib(b[3:0]);
      send_nib(b[7:4]);
    end
    if (extra_nib) send_nib(4'h7);
    idle(1);
  endtask

  task automatic apply_reset();
    @(negedge clk_phy);
    reset_n = 1'b0; phy_rx_dv = 1'b0; phy_data_in = 4'h0;
    repeat (2) @(negedge clk_phy);
    reset_n = 1'b1;
    clear_q();
  endtask

  // Number of recorded bytes in [start, start+n) that differ from the
  // expected ramp or are not spaced two cycles from their predecessor.
  function automatic int bad_bytes(input int start, input int first_val, input int n);
    int errs;
    logic [7:0] e;
    errs = 0;
    if (byte_q.size() < start + n) return n;
    for (int k = 0; k < n; k++) begin
      e = 8'((first_val + k) & 255);
      if (byte_q[start+k] !== e) errs++;
      if (k > 0 && (byte_cyc_q[start+k] - byte_cyc_q[start+k-1]) != 2) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk_phy);
    total++; if (f_data_out !== 8'h00) $display("FAIL rst_data got %h want 00", f_data_out); else passed++;
    total++; if (f_ctrl_out !== 24'h0) $display("FAIL rst_ctrl got %h want 000000", f_ctrl_out); else passed++;
    total++; if ({f_data_valid, f_frame_valid, f_frame_err} !== 3'b000) $display("FAIL rst_strobes got %b want 000", {f_data_valid, f_frame_valid, f_frame_err}); else passed++;
    total++; if ({stat_good, stat_bad} !== 32'h0) $display("FAIL rst_stats got %h want 0", {stat_good, stat_bad}); else passed++;
    reset_n = 1'b1;
    repeat (3) @(negedge clk_phy);
    total++; if ({f_data_valid, f_frame_valid} !== 2'b00) $display("FAIL idle_strobes got %b want 00", {f_data_valid, f_frame_valid}); else passed++;
    clear_q();
  endtask

  task automatic test_single();
    apply_reset();
    send_frame(64, 0, 1'b0, 1'b0);
    idle(5);
    total++; if (byte_q.size() !== 64) $display("FAIL single_nbytes got %0d want 64", byte_q.size()); else passed++;
    total++; if (bad_bytes(0, 0, 64) !== 0) $display("FAIL single_bytes got %0d errors want 0", bad_bytes(0, 0, 64)); else passed++;
    total++; if (ctrl_q.size() !== 1) $display("FAIL single_nframes got %0d want 1", ctrl_q.size()); else passed++;
    if (ctrl_q.size() > 0 && byte_cyc_q.size() > 0) begin
      total++; if (ctrl_q[0] !== 24'h040040) $display("FAIL single_ctrl got %h want 040040", ctrl_q[0]); else passed++;
      total++; if (err_q[0] !== 1'b0) $display("FAIL single_err got %b want 0", err_q[0]); else passed++;
      total++; if (fv_cyc_q[0] !== byte_cyc_q[$] + 1) $display("FAIL single_eof_cycle got %0d want %0d", fv_cyc_q[0], byte_cyc_q[$] + 1); else passed++;
    end
    total++; if (stat_good !== 16'd1) $display("FAIL single_good got %0d want 1", stat_good); else passed++;
    total++; if (f_ctrl_out !== 24'h040040) $display("FAIL single_ctrl_hold got %h want 040040", f_ctrl_out); else passed++;
    total++; if (f_data_out !== 8'h3F) $display("FAIL single_data_hold got %h want 3f", f_data_out); else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_frame(512, 8'h10, 1'b0, 1'b0);
    send_frame(64, 8'hA0, 1'b0, 1'b0);
    idle(4);
    total++; if (byte_q.size() !== 576) $display("FAIL b2b_nbytes got %0d want 576", byte_q.size()); else passed++;
    total++; if (bad_bytes(0, 8'h10, 512) + bad_bytes(512, 8'hA0, 64) !== 0) $display("FAIL b2b_bytes got %0d errors want 0", bad_bytes(0, 8'h10, 512) + bad_bytes(512, 8'hA0, 64)); else passed++;
    total++; if (ctrl_q.size() !== 2) $display("FAIL b2b_nframes got %0d want 2", ctrl_q.size()); else passed++;
    if (ctrl_q.size() == 2) begin
      total++; if (ctrl_q[0] !== 24'h200200) $display("FAIL b2b_ctrl0 got %h want 200200", ctrl_q[0]); else passed++;
      total++; if (ctrl_q[1] !== 24'h040040) $display("FAIL b2b_ctrl1 got %h want 040040", ctrl_q[1]); else passed++;
      total++; if ({err_q[0], err_q[1]} !== 2'b00) $display("FAIL b2b_err got %b want 00", {err_q[0], err_q[1]}); else passed++;
    end
    total++; if (stat_good !== 16'd2) $display("FAIL b2b_good got %0d want 2", stat_good); else passed++;
  endtask

  task automatic test_runt();
    apply_reset();
    send_frame(10, 8'hC8, 1'b0, 1'b0);
    idle(4);
    total++; if (byte_q.size() !== 10) $display("FAIL runt_nbytes got %0d want 10", byte_q.size()); else passed++;
    total++; if (bad_bytes(0, 8'hC8, 10) !== 0) $display("FAIL runt_bytes got %0d errors want 0", bad_bytes(0, 8'hC8, 10)); else passed++;
    total++; if (ctrl_q.size() !== 1) $display("FAIL runt_nframes got %0d want 1", ctrl_q.size()); else passed++;
    if (ctrl_q.size() > 0) begin
      total++; if (ctrl_q[0] !== 24'h00A00A) $display("FAIL runt_ctrl got %h want 00a00a", ctrl_q[0]); else passed++;
      total++; if (err_q[0] !== 1'b1) $display("FAIL runt_err got %b want 1", err_q[0]); else passed++;
    end
    total++; if ({stat_good, stat_bad} !== {16'd0, 16'd1}) $display("FAIL runt_stats got %h want 00000001", {stat_good, stat_bad}); else passed++;
  endtask

  task automatic test_dangling_nibble();
    apply_reset();
    send_frame(64, 8'h55, 1'b1, 1'b0);
    idle(4);
    total++; if (byte_q.size() !== 64) $display("FAIL dangle_nbytes got %0d want 64", byte_q.size()); else passed++;
    total++; if (bad_bytes(0, 8'h55, 64) !== 0) $display("FAIL dangle_bytes got %0d errors want 0", bad_bytes(0, 8'h55, 64)); else passed++;
    total++; if (ctrl_q.size() !== 1) $display("FAIL dangle_nframes got %0d want 1", ctrl_q.size()); else passed++;
    if (ctrl_q.size() > 0) begin
      total++; if (ctrl_q[0] !== 24'h040040) $display("FAIL dangle_ctrl got %h want 040040", ctrl_q[0]); else passed++;
      total++; if (err_q[0] !== 1'b1) $display("FAIL dangle_err got %b want 1", err_q[0]); else passed++;
    end
    total++; if (stat_bad !== 16'd1) $display("FAIL dangle_bad got %0d want 1", stat_bad); else passed++;
  endtask

  task automatic test_bad_preamble();
    apply_reset();
    send_frame(64, 0, 1'b0, 1'b1);
    idle(4);
    total++; if (byte_q.size() !== 0) $display("FAIL badpre_nbytes got %0d want 0", byte_q.size()); else passed++;
    total++; if (ctrl_q.size() !== 0) $display("FAIL badpre_nframes got %0d want 0", ctrl_q.size()); else passed++;
    total++; if ({stat_good, stat_bad} !== 32'h0) $display("FAIL badpre_stats got %h want 0", {stat_good, stat_bad}); else passed++;
  endtask

  task automatic test_oversize();
    apply_reset();
    send_frame(2100, 0, 1'b0, 1'b0);
    idle(4);
    total++; if (byte_q.size() !== 2047) $display("FAIL over_nbytes got %0d want 2047", byte_q.size()); else passed++;
    total++; if (bad_bytes(0, 0, 2047) !== 0) $display("FAIL over_bytes got %0d errors want 0", bad_bytes(0, 0, 2047)); else passed++;
    total++; if (ctrl_q.size() !== 1) $display("FAIL over_nframes got %0d want 1", ctrl_q.size()); else passed++;
    if (ctrl_q.size() > 0) begin
      total++; if (ctrl_q[0] !== 24'h800800) $display("FAIL over_ctrl got %h want 800800", ctrl_q[0]); else passed++;
      total++; if (err_q[0] !== 1'b1) $display("FAIL over_err got %b want 1", err_q[0]); else passed++;
    end
    total++; if ({stat_good, stat_bad} !== {16'd0, 16'd1}) $display("FAIL over_stats got %h want 00000001", {stat_good, stat_bad}); else passed++;
  endtask

  // Runs straight after the oversize frame so reset has state to clear.
  task automatic test_reset_mid_frame();
    clear_q();
    send_preamble(1'b0);
    for (int i = 0; i < 30; i++) begin
      send_nib(4'(i & 15));
      send_nib(4'(i >> 4));
    end
    send_nib(4'hE);
    @(posedge clk_phy);
    #2 reset_n = 1'b0;
    #1;
    total++; if (f_data_out !== 8'h00) $display("FAIL rmid_data got %h want 00", f_data_out); else passed++;
    total++; if ({f_ctrl_out, f_frame_err} !== 25'h0) $display("FAIL rmid_ctrl got %h want 0", {f_ctrl_out, f_frame_err}); else passed++;
    total++; if ({stat_good, stat_bad} !== 32'h0) $display("FAIL rmid_stats got %h want 0", {stat_good, stat_bad}); else passed++;
    clear_q();
    send_nib(4'h1);
    send_nib(4'h2);
    @(negedge clk_phy);
    reset_n = 1'b1; phy_rx_dv = 1'b1; phy_data_in = 4'h3;
    send_nib(4'h5); send_nib(4'h5); send_nib(4'hD); send_nib(4'h1);
    idle(4);
    total++; if (byte_q.size() + ctrl_q.size() !== 0) $display("FAIL rmid_aborted_strobes got %0d want 0", byte_q.size() + ctrl_q.size()); else passed++;
    send_frame(64, 8'h40, 1'b0, 1'b0);
    idle(4);
    total++; if (bad_bytes(0, 8'h40, 64) !== 0) $display("FAIL rmid_next_bytes got %0d errors want 0", bad_bytes(0, 8'h40, 64)); else passed++;
    total++; if (ctrl_q.size() !== 1) $display("FAIL rmid_next_nframes got %0d want 1", ctrl_q.size()); else passed++;
    if (ctrl_q.size() > 0) begin
      total++; if ({ctrl_q[0], err_q[0]} !== {24'h040040, 1'b0}) $display("FAIL rmid_next_ctrl got %h/%b want 040040/0", ctrl_q[0], err_q[0]); else passed++;
    end
    total++; if ({stat_good, stat_bad} !== {16'd1, 16'd0}) $display("FAIL rmid_stats_after got %h want 00010000", {stat_good, stat_bad}); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_runt();
    test_dangling_nibble();
    test_bad_preamble();
    test_oversize();
    test_reset_mid_frame();
    total++; if (overlap !== 0) $display("FAIL strobe_overlap got %0d want 0", overlap); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rcv_deframer.md
# rcv_deframer

Receive-side deframer: the PHY-facing counterpart of the transmit path. Samples the 4-bit PHY nibble stream, strips the preamble/SFD, and reassembles bytes low nibble first. Presents each byte to the fabric, then issues a one-cycle end-of-frame control word in the same 24-bit format the transmit control block consumes. Lives in the `clk_phy` domain, between the PHY pins and the receive FIFO/fabric.

## Interface
- Parameters:
  - `MIN_LEN`, 64: minimum legal payload bytes; shorter frames are runts.
  - `MAX_LEN`, 2047: maximum legal payload bytes.
  - `STAT_W`, 16: width of the frame statistics counters.
- Ports:
  - `clk_phy` in 1: PHY clock; the only clock.
  - `reset_n` in 1: asynchronous, active-low reset.
  - `phy_data_in` in 4: receive nibble.
  - `phy_rx_dv` in 1: nibble valid; high for the whole frame.
  - `f_data_out` out 8: reassembled payload byte.
  - `f_data_valid` out 1: one-cycle strobe; `f_data_out` is valid.
  - `f_ctrl_out` out 24: `{len[11:0], len[11:0]}`; valid with `f_frame_valid`.
  - `f_frame_valid` out 1: one-cycle end-of-frame strobe.
  - `f_frame_err` out 1: valid with `f_frame_valid`; frame is runt, misaligned or oversize.
  - `stat_good` out STAT_W: saturating count of good frames.
  - `stat_bad` out STAT_W: saturating count of errored frames.

## Operation
- States: IDLE, PRE, DATA, DROP. All inputs are sampled on rising `clk_phy`. A nibble is meaningful only when `phy_rx_dv` = 1.
- IDLE:
  - `phy_rx_dv` = 1 goes to PRE.
  - The nibble sampled on that edge counts as the first preamble nibble.
- PRE (preamble `0x55`…, SFD `0xD5`, low nibble first):
  - Nibble 5 increments `pre_cnt`, which saturates at 3.
  - Nibble D with `pre_cnt` ≥ 2 goes to DATA; `phase` is cleared and `byte_cnt` is cleared.
  - Any other nibble, or D with `pre_cnt` < 2, goes to DROP with `silent` = 1.
  - `phy_rx_dv` = 0 returns to IDLE. No outputs are issued.
- DATA:
  - `phase` = 0: latch the nibble as low[3:0]; set `phase` = 1.
  - `phase` = 1: load `f_data_out` = {nibble, low}, pulse `f_data_valid`, increment `byte_cnt` (12 bits), set `phase` = 0.
  - If the byte would be number `MAX_LEN`+1: do not deliver it. Set `byte_cnt` = `MAX_LEN`+1 (0x800), `oversize` = 1, `silent` = 0, and go to DROP.
  - `phy_rx_dv` = 0 ends the frame. Pulse `f_frame_valid` with `f_ctrl_out` = {byte_cnt, byte_cnt}.
  - `f_frame_err` = (`phase` = 1) | (`byte_cnt` < `MIN_LEN`). A dangling nibble is discarded and not counted.
  - Then go to IDLE.
- DROP: ignore nibbles until `phy_rx_dv` = 0.
  - If `silent` = 1: go to IDLE with no strobe.
  - Otherwise: pulse `f_frame_valid` with `f_frame_err` = 1 and `f_ctrl_out` = {0x800, 0x800}, then go to IDLE.
- Statistics: on every `f_frame_valid`, increment `stat_good` or `stat_bad` according to `f_frame_err`. Both saturate at all-ones; there is no wrap.
- `f_frame_valid` and `f_data_valid` are never high in the same cycle.

## Timing
- All outputs are registered. Reset values:
  - `f_data_out` = 0, `f_data_valid` = 0, `f_ctrl_out` = 0, `f_frame_valid` = 0, `f_frame_err` = 0.
  - `stat_good` = 0, `stat_bad` = 0.
  - State = IDLE; `phase`, `pre_cnt`, `byte_cnt`, `oversize` and `silent` are all 0.
- Byte latency: `f_data_valid` is high in the cycle after the edge that sampled the high nibble. Strobes are spaced exactly 2 cycles apart.
- End of frame: `f_frame_valid` is high in the cycle after the edge that sampled `phy_rx_dv` = 0. This is the cycle immediately after the last `f_data_valid`.
- `f_frame_err` and `f_ctrl_out` hold their value until the next `f_frame_valid`. `f_data_out` holds its value until the next byte.
- Back-to-back frames:
  - One IDLE cycle (`phy_rx_dv` low for 1 cycle) is sufficient.
  - A new frame may begin in the same cycle that `f_frame_valid` is high.
- Reset mid-frame:
  - Outputs clear immediately, since reset is asynchronous. No `f_frame_valid` is issued for the aborted frame.
  - After `reset_n` rises, the block waits in IDLE. If `phy_rx_dv` is still high, the nibbles of the aborted frame are parsed as a preamble; unless they match, that leads to silent DROP.

## Test plan
- 7×`0x55` + `0xD5` preamble, then 64 payload bytes 0x00..0x3F -> 64 `f_data_valid` pulses 2 cycles apart carrying 0x00..0x3F, then `f_frame_valid` with `f_ctrl_out` = 0x040040, `f_frame_err` = 0, and `stat_good` = 1.
- 512-byte frame followed by a 64-byte frame with one idle cycle between -> `f_ctrl_out` = 0x200200 then 0x040040, both with `f_frame_err` = 0, and `stat_good` = 2.
- 10-byte runt -> 10 bytes delivered, `f_ctrl_out` = 0x00A00A, `f_frame_err` = 1, `stat_bad` = 1.
- 64 bytes plus 1 trailing nibble -> 64 bytes delivered, `f_ctrl_out` = 0x040040, `f_frame_err` = 1.
- Preamble containing nibble 0x3, or 2100-byte frame ->
  - Bad preamble: no strobes at all.
  - Oversize: 2047 bytes delivered, then one `f_frame_valid` with `f_ctrl_out` = 0x800800 and `f_frame_err` = 1.
- `reset_n` pulled low at byte 30 of a 64-byte frame -> all outputs 0 immediately. No `f_frame_valid` for that frame. The next clean 64-byte frame is received normally.
